mash_cfg_sequencer: RTL

//  Sequences a frequency/phase reconfiguration of the NCSP MASH top. Accepts one

---
 rtl/mash_cfg_sequencer_pkg.sv | 38 +++
 rtl/mash_cycle_timer.sv | 34 +++
 rtl/mash_cfg_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mash_cfg_sequencer_pkg.sv
// Shared types for the MASH reconfiguration sequencer: FSM state encoding,
// configuration field widths and the applied-configuration record.
package mash_cfg_sequencer_pkg;

  localparam int FRAC_W  = 24;
  localparam int INT_W   = 8;
  localparam int SEED_W  = 12;
  localparam int ORDER_W = 2;
  localparam int MBIT_W  = 4;
  localparam int PHADD_W = 12;
  localparam int STEP_W  = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MRST   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PHASE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [FRAC_W-1:0]  frac;
    logic [INT_W-1:0]   intp;
    logic [SEED_W-1:0]  seed;
    logic [ORDER_W-1:0] order;
    logic [MBIT_W-1:0]  mbit;
    logic [PHADD_W-1:0] phadd;
    logic [STEP_W-1:0]  steps;
  } cfg_t;

  // The timer expires on the cycle its count reaches zero, so a dwell of
  // N cycles is loaded as N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mash_cycle_timer.sv
// Loadable down-counter shared by all timed sequencer states; o_expire is
// high while the count sits at zero.
module mash_cycle_timer
  import mash_cfg_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == '0);

endmodule

// File: rtl/mash_cfg_sequencer.sv
// Applies one MASH configuration per handshake: mash-reset, sync settle,
// N phase-adjust pulses, then re-enable of the fractional path.
module mash_cfg_sequencer
  import mash_cfg_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYC  = 4,
  parameter int unsigned SYNC_DLY = 3,
  parameter int unsigned PH_GAP   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [FRAC_W-1:0]  i_cfg_frac,
  input  logic [INT_W-1:0]   i_cfg_int,
  input  logic [SEED_W-1:0]  i_cfg_seed,
  input  logic [ORDER_W-1:0] i_cfg_order,
  input  logic [MBIT_W-1:0]  i_cfg_mash_bit,
  input  logic [PHADD_W-1:0] i_cfg_phaseadd,
  input  logic [STEP_W-1:0]  i_cfg_phase_steps,
  input  logic               i_abort,
  output logic [7:0]         o_msb,
  output logic [7:0]         o_isb,
  output logic [7:0]         o_lsb,
  output logic [INT_W-1:0]   o_int,
  output logic [SEED_W-1:0]  o_seed,
  output logic [ORDER_W-1:0] o_sel_order,
  output logic [MBIT_W-1:0]  o_mash_bit,
  output logic [PHADD_W-1:0] o_phaseadd,
  output logic               o_mashreseten,
  output logic               o_phaseadjusten,
  output logic               o_sel_frac,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] LD_RST   = cnt_load(RST_CYC);
  localparam logic [CNT_W-1:0] LD_SYNC  = cnt_load(SYNC_DLY);
  localparam logic [CNT_W-1:0] LD_PHASE = cnt_load(PH_GAP + 1);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [STEP_W-1:0] pcnt_q, pcnt_d;
  logic              mrst_q, mrst_d;
  logic              padj_q, padj_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_expire;
  logic              accept;
  logic              abort_act;

  assign accept    = (state_q == ST_IDLE) && i_cfg_valid;
  assign abort_act = (state_q != ST_IDLE) && i_abort;

  mash_cycle_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_expire   (tmr_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // pcnt holds the pulses still owed after the one currently in flight.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          state_d  = ST_MRST;
          tmr_load = 1'b1;
          tmr_val  = LD_RST;
        end
      end
      ST_MRST: begin
        if (tmr_expire) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = LD_SYNC;
        end
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          if (cfg_q.steps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_PHASE;
            tmr_load = 1'b1;
            tmr_val  = LD_PHASE;
            pcnt_d   = cfg_q.steps - STEP_W'(1);
          end
        end
      end
      ST_PHASE: begin
        if (tmr_expire) begin
          if (pcnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = LD_PHASE;
            pcnt_d   = pcnt_q - STEP_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d  = ST_IDLE;
      tmr_load = 1'b0;
    end
  end

  always_comb begin
    cfg_d  = cfg_q;
    sel_d  = sel_q;
    mrst_d = (state_d == ST_MRST);
    padj_d = (state_d == ST_PHASE) && ((state_q != ST_PHASE) || tmr_expire);
    done_d = (state_d == ST_DONE);
    if (accept) begin
      cfg_d.frac  = i_cfg_frac;
      cfg_d.intp  = i_cfg_int;
      cfg_d.seed  = i_cfg_seed;
      cfg_d.order = i_cfg_order;
      cfg_d.mbit  = i_cfg_mash_bit;
      cfg_d.phadd = i_cfg_phaseadd;
      cfg_d.steps = i_cfg_phase_steps;
      sel_d       = 1'b0;
    end else if (abort_act) begin
      sel_d = 1'b0;
    end else if (state_d == ST_DONE) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cfg_q  <= '0;
      mrst_q <= 1'b0;
      padj_q <= 1'b0;
      sel_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      mrst_q <= mrst_d;
      padj_q <= padj_d;
      sel_q  <= sel_d;
      done_q <= done_d;
    end
  end

  assign o_cfg_ready     = (state_q == ST_IDLE);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_msb           = cfg_q.frac[23:16];
  assign o_isb           = cfg_q.frac[15:8];
  assign o_lsb           = cfg_q.frac[7:0];
  assign o_int           = cfg_q.intp;
  assign o_seed          = cfg_q.seed;
  assign o_sel_order     = cfg_q.order;
  assign o_mash_bit      = cfg_q.mbit;
  assign o_phaseadd      = cfg_q.phadd;
  assign o_mashreseten   = mrst_q;
  assign o_phaseadjusten = padj_q;
  assign o_sel_frac      = sel_q;
  assign o_done          = done_q;

endmodule
